// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer: FSM state encoding and
// the default qualification constants used by board tops.
package input_debouncer_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } deb_state_t;

  // 10 ms at a 50 MHz system clock.
  localparam int DEFAULT_STABLE_CYCLES = 500000;
  localparam int DEFAULT_SYNC_STAGES   = 2;

endpackage

// File: rtl/input_debouncer_sync_nff.sv
// N-flop synchronizer bringing one asynchronous bit into the clk domain.
module sync_nff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] stages;

  // Shift the raw bit through the chain; the last flop is the safe copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[N-2:0], d};
    end
  end

  assign q = stages[N-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces one raw board input into a clean level for Find_Z.B, with
// single-cycle edge pulses and a busy flag while a change is qualified.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic b_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_q;
  deb_state_t       state;
  deb_state_t       next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  sync_nff #(
    .N (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (raw_in),
    .q     (sync_q)
  );

  // Next-state and counter logic: a candidate level must hold for
  // STABLE_CYCLES consecutive cycles; any reversion restarts from zero.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      S_LOW: begin
        if (sync_q) begin
          next_state = S_WAIT_HIGH;
          cnt_next   = '0;
        end
      end
      S_WAIT_HIGH: begin
        if (!sync_q) begin
          next_state = S_LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          next_state = S_HIGH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_HIGH: begin
        if (!sync_q) begin
          next_state = S_WAIT_LOW;
          cnt_next   = '0;
        end
      end
      S_WAIT_LOW: begin
        if (sync_q) begin
          next_state = S_HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          next_state = S_LOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        next_state = S_LOW;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter and registered outputs decoded from the upcoming state
  // so they line up with the state register on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_LOW;
      cnt        <= '0;
      b_out      <= 1'b0;
      busy       <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= cnt_next;
      b_out      <= (next_state == S_HIGH) || (next_state == S_WAIT_LOW);
      busy       <= (next_state == S_WAIT_HIGH) || (next_state == S_WAIT_LOW);
      rise_pulse <= (state == S_WAIT_HIGH) && (next_state == S_HIGH);
      fall_pulse <= (state == S_WAIT_LOW) && (next_state == S_LOW);
    end
  end

endmodule
